// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO: configurable data/parity/stop/baud.
// Ports: clk, rst, wr_data/wr_valid/wr_ready, tx, busy, fifo_count, overflow.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [AW:0]          fifo_count,
  output logic                 overflow
);

  localparam int CPB = CLK_FREQ / BAUDRATE;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CPB_LAST = CW'(CPB - 1);
  localparam logic [3:0] DB_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SB_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  state_t               state, state_n;
  logic [CW-1:0]        baud_cnt, baud_n;
  logic [3:0]           bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_q, par_n;
  logic                 tx_q, tx_n;
  logic                 push, pop;
  logic                 bit_end, has_data;

  assign has_data   = (count != '0);
  assign wr_ready   = (count != DEPTH_C);
  assign push       = wr_valid & wr_ready;
  assign overflow   = wr_valid & ~wr_ready;
  assign bit_end    = (baud_cnt == CPB_LAST);
  assign busy       = (state != S_IDLE);
  assign tx         = tx_q;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shreg    <= shreg_n;
      par_q    <= par_n;
      tx_q     <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + 1'b1;
    bit_n   = bit_idx;
    shreg_n = shreg;
    par_n   = par_q;
    pop     = 1'b0;
    tx_n    = 1'b1;
    unique case (state)
      S_IDLE: begin
        baud_n = '0;
        if (has_data) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (bit_idx == DB_LAST) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          bit_n   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_idx == SB_LAST) begin
            // back-to-back: next word leaves with no idle cycle
            if (has_data) begin
              pop     = 1'b1;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (bit_end)
      baud_n = '0;
    if (pop) begin
      shreg_n = mem[rd_ptr];
      par_n   = (^mem[rd_ptr]) ^ ODD;
      baud_n  = '0;
      bit_n   = '0;
    end
    // tx registered from the next state so the pin never glitches
    unique case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations checked against a
// per-cycle line-level model plus directed literal expectations.
module tb_uart_tx_fifo;

  localparam int CF    = 1_000_000;
  localparam int BR    = 100_000;
  localparam int CPB   = 10;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wd [4];
  logic [3:0] wv;
  logic [3:0] txv, busyv, rdyv, ovfv;
  logic [4:0] cntv [4];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(CF), .BAUDRATE(BR), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
    .clk(clk), .rst(rst), .wr_data(wd[0]), .wr_valid(wv[0]),
    .wr_ready(rdyv[0]), .tx(txv[0]), .busy(busyv[0]),
    .fifo_count(cntv[0]), .overflow(ovfv[0]));

  uart_tx_fifo #(.CLK_FREQ(CF), .BAUDRATE(BR), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u1 (
    .clk(clk), .rst(rst), .wr_data(wd[1]), .wr_valid(wv[1]),
    .wr_ready(rdyv[1]), .tx(txv[1]), .busy(busyv[1]),
    .fifo_count(cntv[1]), .overflow(ovfv[1]));

  uart_tx_fifo #(.CLK_FREQ(CF), .BAUDRATE(BR), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u2 (
    .clk(clk), .rst(rst), .wr_data(wd[2]), .wr_valid(wv[2]),
    .wr_ready(rdyv[2]), .tx(txv[2]), .busy(busyv[2]),
    .fifo_count(cntv[2]), .overflow(ovfv[2]));

  uart_tx_fifo #(.CLK_FREQ(CF), .BAUDRATE(BR), .DATA_BITS(7),
    .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u3 (
    .clk(clk), .rst(rst), .wr_data(wd[3][6:0]), .wr_valid(wv[3]),
    .wr_ready(rdyv[3]), .tx(txv[3]), .busy(busyv[3]),
    .fifo_count(cntv[3]), .overflow(ovfv[3]));

  int nb [4] = '{8, 8, 8, 7};
  int np [4] = '{0, 2, 1, 0};
  int ns [4] = '{1, 1, 1, 2};

  // expected line level per future cycle; bit1 marks a frame's first cycle
  int   lq [4][$];
  int   mcnt [4];
  logic exp_tx [4];
  logic exp_busy [4];

  int checks = 0;
  int failures = 0;

  int ts [4][120];
  int bs [4][120];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int d, input int w);
    int ones;
    int pb;
    ones = $countones(w & ((1 << nb[d]) - 1));
    for (int c = 0; c < CPB; c++)
      lq[d].push_back(c == 0 ? 2 : 0);
    for (int b = 0; b < nb[d]; b++)
      for (int c = 0; c < CPB; c++)
        lq[d].push_back((w >> b) & 1);
    if (np[d] != 0) begin
      pb = (np[d] == 2) ? (ones % 2) : (1 - (ones % 2));
      for (int c = 0; c < CPB; c++)
        lq[d].push_back(pb);
    end
    for (int c = 0; c < ns[d] * CPB; c++)
      lq[d].push_back(1);
  endtask

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 4; d++) begin
      int  v;
      bit  acc;
      if (rst) begin
        lq[d].delete();
        mcnt[d] = 0;
        exp_tx[d] = 1'b1;
        exp_busy[d] = 1'b0;
      end else begin
        acc = wv[d] && (mcnt[d] != DEPTH);
        if (lq[d].size() != 0) begin
          v = lq[d].pop_front();
          exp_tx[d] = ((v & 1) != 0);
          exp_busy[d] = 1'b1;
          if ((v & 2) != 0)
            mcnt[d]--;
        end else begin
          exp_tx[d] = 1'b1;
          exp_busy[d] = 1'b0;
        end
        if (acc) begin
          mcnt[d]++;
          push_frame(d, int'(wd[d]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("tx%0d", d), int'(txv[d]), int'(exp_tx[d]));
        chk($sformatf("busy%0d", d), int'(busyv[d]), int'(exp_busy[d]));
        chk($sformatf("cnt%0d", d), int'(cntv[d]), mcnt[d]);
        chk($sformatf("rdy%0d", d), int'(rdyv[d]),
            int'(mcnt[d] != DEPTH));
        chk($sformatf("ovf%0d", d), int'(ovfv[d]),
            int'(wv[d] && mcnt[d] == DEPTH));
      end
    end
  end

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #3;
      for (int d = 0; d < 4; d++) begin
        ts[d][i] = int'(txv[d]);
        bs[d][i] = int'(busyv[d]);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int acc, ovf, hi, maxc, n, lows;
    rst = 1'b1;
    wv  = '0;
    for (int d = 0; d < 4; d++) wd[d] = '0;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 4; d++) begin
      chk("rst_tx", int'(txv[d]), 1);
      chk("rst_rdy", int'(rdyv[d]), 1);
      chk("rst_busy", int'(busyv[d]), 0);
      chk("rst_cnt", int'(cntv[d]), 0);
      chk("rst_ovf", int'(ovfv[d]), 0);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 8N1 0xA5
    @(posedge clk); #2;
    wd[0] = 8'hA5; wv[0] = 1'b1;
    @(posedge clk); #2;
    wv[0] = 1'b0;
    chk("a5_pre_tx", int'(txv[0]), 1);
    capture(101);
    chk("a5_start_edge", ts[0][0], 0);
    for (int k = 0; k < 10; k++)
      chk($sformatf("a5_bit%0d", k), ts[0][10*k+5], a5[k]);
    chk("a5_bit9_last", ts[0][99], 1);
    chk("a5_busy99", bs[0][99], 1);
    chk("a5_busy100", bs[0][100], 0);
    repeat (5) @(posedge clk);

    // parity: even on u1, odd on u2, word 0x07
    @(posedge clk); #2;
    wd[1] = 8'h07; wd[2] = 8'h07; wv[1] = 1'b1; wv[2] = 1'b1;
    @(posedge clk); #2;
    wv[1] = 1'b0; wv[2] = 1'b0;
    capture(111);
    chk("even_d7", ts[1][85], 0);
    chk("even_par", ts[1][95], 1);
    chk("odd_par", ts[2][95], 0);
    chk("even_stop", ts[1][105], 1);
    chk("par_busy109", bs[1][109], 1);
    chk("par_busy110", bs[1][110], 0);
    chk("odd_busy110", bs[2][110], 0);
    repeat (5) @(posedge clk);

    // 7 data bits, 2 stop bits, word 0x7F
    @(posedge clk); #2;
    wd[3] = 8'h7F; wv[3] = 1'b1;
    @(posedge clk); #2;
    wv[3] = 1'b0;
    capture(101);
    chk("s2_start", ts[3][5], 0);
    for (int k = 1; k <= 7; k++)
      chk($sformatf("s2_d%0d", k - 1), ts[3][10*k+5], 1);
    chk("s2_stop1", ts[3][85], 1);
    chk("s2_stop2", ts[3][95], 1);
    chk("s2_busy99", bs[3][99], 1);
    chk("s2_busy100", bs[3][100], 0);
    repeat (5) @(posedge clk);

    // hold wr_valid 20 cycles on u0
    acc = 0; ovf = 0; hi = 0; maxc = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #2;
      wv[0] = 1'b1; wd[0] = 8'(j + 1);
      #3;
      if (rdyv[0]) acc++;
      if (ovfv[0]) ovf++;
      if (busyv[0]) hi++;
      if (int'(cntv[0]) > maxc) maxc = int'(cntv[0]);
    end
    @(posedge clk); #2;
    wv[0] = 1'b0;
    #3;
    n = 0;
    while (busyv[0] && n < 2500) begin
      hi++; n++;
      @(posedge clk); #5;
    end
    chk("burst_drain", int'(busyv[0]), 0);
    chk("burst_acc", acc, 17);
    chk("burst_ovf", ovf, 3);
    chk("burst_maxcnt", maxc, 16);
    chk("burst_busy_cycles", hi, 1700);
    repeat (5) @(posedge clk);

    // reset mid-frame
    @(posedge clk); #2;
    wv[0] = 1'b1; wd[0] = 8'h11;
    @(posedge clk); #2;
    wd[0] = 8'h22;
    @(posedge clk); #2;
    wd[0] = 8'h33;
    @(posedge clk); #2;
    wv[0] = 1'b0;
    repeat (39) @(posedge clk);
    #2;
    chk("mid_busy", int'(busyv[0]), 1);
    chk("mid_cnt", int'(cntv[0]), 2);
    chk("mid_bit3", int'(txv[0]), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", int'(txv[0]), 1);
    chk("mid_rst_cnt", int'(cntv[0]), 0);
    chk("mid_rst_busy", int'(busyv[0]), 0);
    chk("mid_rst_rdy", int'(rdyv[0]), 1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #3;
      if (!txv[0] || busyv[0]) lows++;
    end
    chk("post_rst_idle", lows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
